// File: rtl/score_digit_driver.sv
// score_digit_driver: score/high-score counters, double-dabble BCD conversion, atomic 8-digit commit
module score_digit_driver #(
  parameter int         SCORE_W   = 14,
  parameter int         MAX_SCORE = 9999,
  parameter logic [4:0] BLANK     = 5'd31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       score_inc,
  input  logic       score_clr,
  input  logic [2:0] refresh_rate,
  output logic [4:0] digit_holder,
  output logic       busy
);
  localparam int CW = $clog2(SCORE_W);
  typedef enum logic [1:0] {IDLE, CONV_S, CONV_H, COMMIT} state_t;
  state_t state, state_nx;
  logic [SCORE_W-1:0] score, high, score_nx, sr;
  logic dirty, bump, last_step, nz;
  logic [15:0] bcd, adj, bcd_step, score_bcd, src;
  logic [CW-1:0] cnt;
  logic [4:0] digits [8];
  logic [4:0] commit_d [8];
  // next score: clear wins, increment saturates and then counts as no change
  always_comb begin
    score_nx = score_clr ? '0 : (score_inc && score != SCORE_W'(MAX_SCORE)) ? score + 1'b1 : score;
    bump = score_clr | (score_inc && score != SCORE_W'(MAX_SCORE));
  end
  // score and high score track together; a new pulse keeps dirty set even as a conversion starts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      score <= '0;
      high  <= '0;
      dirty <= 1'b0;
    end else begin
      score <= score_nx;
      if (score_nx > high) high <= score_nx;
      if (bump) dirty <= 1'b1;
      else if (state == IDLE) dirty <= 1'b0;
    end
  // one double-dabble step: add 3 to every nibble >= 5, then shift in the snapshot MSB
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    bcd_step = {adj[14:0], sr[SCORE_W-1]};
    last_step = cnt == CW'(SCORE_W - 1);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // sequencing: score conversion, then high-score conversion, then a single commit
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = dirty ? CONV_S : IDLE;
      CONV_S:  state_nx = last_step ? CONV_H : CONV_S;
      CONV_H:  state_nx = last_step ? COMMIT : CONV_H;
      default: state_nx = IDLE;
    endcase
  end
  // leading-zero blanking per 4-digit group; units always shown
  always_comb begin
    src = '0;
    nz = 1'b0;
    for (int g = 0; g < 2; g++) begin
      src = g == 0 ? score_bcd : bcd;
      nz = 1'b0;
      for (int k = 3; k >= 0; k--) begin
        nz = nz | (src[4*k+:4] != 4'd0);
        commit_d[4*g+k] = (k == 0 || nz) ? {1'b0, src[4*k+:4]} : BLANK;
      end
    end
  end
  // conversion datapath and digit register file, written only in COMMIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      bcd <= '0;
      cnt <= '0;
      score_bcd <= '0;
      for (int i = 0; i < 8; i++) digits[i] <= (i % 4 == 0) ? 5'd0 : BLANK;
    end else begin
      case (state)
        IDLE: if (dirty) begin
          sr <= score;
          bcd <= '0;
          cnt <= '0;
        end
        CONV_S: if (last_step) begin
          score_bcd <= bcd_step;
          sr <= high;
          bcd <= '0;
          cnt <= '0;
        end else begin
          sr <= sr << 1;
          bcd <= bcd_step;
          cnt <= cnt + 1'b1;
        end
        CONV_H: begin
          sr <= sr << 1;
          bcd <= bcd_step;
          cnt <= cnt + 1'b1;
        end
        default: digits <= commit_d;
      endcase
    end
  assign digit_holder = digits[refresh_rate];
  assign busy = state != IDLE;
endmodule

// File: tb/tb_score_digit_driver.sv
// tb_score_digit_driver: randomized scoreboard bench with a decimal reference model
`timescale 1ns/100ps
module tb_score_digit_driver;
  logic clk = 1'b0, rst_n = 1'b0, score_inc = 1'b0, score_clr = 1'b0;
  logic [2:0] refresh_rate = 3'd0;
  logic [4:0] digit_holder;
  logic busy;
  typedef struct {int s; int h;} exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0, rises = 0, m_s = 0, m_h = 0;
  logic prev_busy = 1'b0, armed = 1'b0;
  int low_cnt = 0;
  logic [39:0] mon_d;
  exp_t mon_e;

  score_digit_driver dut (
    .clk(clk), .rst_n(rst_n), .score_inc(score_inc), .score_clr(score_clr),
    .refresh_rate(refresh_rate), .digit_holder(digit_holder), .busy(busy)
  );

  always #5 clk = ~clk;

  // expected display: decimal digits of each value, leading zeros blanked, units always lit
  function automatic logic [39:0] model(int s, int h);
    logic [39:0] r;
    int v, k, pw;
    r = '0;
    for (int p = 0; p < 8; p++) begin
      v = p < 4 ? s : h;
      k = p % 4;
      pw = k == 0 ? 1 : k == 1 ? 10 : k == 2 ? 100 : 1000;
      r[p*5+:5] = (k == 0 || v >= pw) ? 5'((v / pw) % 10) : 5'd31;
    end
    return r;
  endfunction

  task automatic read_disp(output logic [39:0] d);
    d = '0;
    for (int p = 0; p < 8; p++) begin
      refresh_rate = 3'(p);
      #0.5;
      d[p*5+:5] = digit_holder;
    end
  endtask

  task automatic check(string name, logic [39:0] act, logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_disp(string name, int s, int h);
    logic [39:0] d;
    read_disp(d);
    check(name, d, model(s, h));
  endtask

  // one-cycle pulse sampled by the posedge between the two negedges; model updated and expectation queued
  task automatic pulse(logic inc, logic clr);
    @(negedge clk);
    score_inc = inc;
    score_clr = clr;
    if (clr) m_s = 0;
    else if (inc && m_s < 9999) m_s++;
    if (m_s > m_h) m_h = m_s;
    sb.push_back('{m_s, m_h});
    @(negedge clk);
    score_inc = 1'b0;
    score_clr = 1'b0;
  endtask

  // wait until busy has been low for three negedges, bounded
  task automatic settle(string name);
    int lows, t;
    lows = 0;
    t = 0;
    while (lows < 3 && t < 400) begin
      @(negedge clk);
      t++;
      lows = busy ? 0 : lows + 1;
    end
    if (lows < 3) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, t);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_s = 0;
    m_h = 0;
    sb.delete();
  endtask

  // monitor: once busy has stayed low for two negedges the display must show the latest queued values
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      armed = 1'b0;
      low_cnt = 0;
    end else begin
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      if (busy) begin
        armed = 1'b1;
        low_cnt = 0;
      end else begin
        low_cnt++;
        if (armed && low_cnt == 2) begin
          armed = 1'b0;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit: conversion with no queued expectation");
          end else begin
            mon_e = sb[$];
            sb.delete();
            read_disp(mon_d);
            check("commit", mon_d, model(mon_e.s, mon_e.h));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, gap;
    logic [39:0] d;
    repeat (3) @(negedge clk);
    check_disp("reset_digits", 0, 0);
    check("reset_busy", 40'(busy), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // single increment latency
    repeat (5) @(negedge clk);
    pulse(1'b1, 1'b0);
    check("busy_e0", 40'(busy), 40'd0);
    @(negedge clk);
    check("busy_e1", 40'(busy), 40'd1);
    repeat (28) @(negedge clk);
    check("busy_e29", 40'(busy), 40'd1);
    refresh_rate = 3'd0;
    #1 check("lat_e29_pos0", 40'(digit_holder), 40'd0);
    refresh_rate = 3'd4;
    #1 check("lat_e29_pos4", 40'(digit_holder), 40'd0);
    @(negedge clk);
    refresh_rate = 3'd0;
    #1 check("lat_e30_pos0", 40'(digit_holder), 40'd1);
    refresh_rate = 3'd4;
    #1 check("lat_e30_pos4", 40'(digit_holder), 40'd1);
    settle("single");
    @(negedge clk);
    check_disp("single_final", 1, 1);
    // reset mid-simulation
    do_reset();
    @(negedge clk);
    check_disp("reset_mid", 0, 0);
    check("reset_mid_busy", 40'(busy), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // multi-digit, spaced pulses
    for (int i = 0; i < 12; i++) begin
      pulse(1'b1, 1'b0);
      repeat (40) @(negedge clk);
    end
    settle("multi");
    check_disp("multi_final", 12, 12);
    pulse(1'b0, 1'b1);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      repeat (40) @(negedge clk);
    end
    settle("clr3");
    check_disp("clr3_final", 3, 12);
    // coalescing: five pulses inside one busy window with random spacing
    pulse(1'b0, 1'b1);
    settle("coal_clr");
    r0 = rises;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(4, 1);
      repeat (gap) @(negedge clk);
      pulse(1'b1, 1'b0);
    end
    settle("coal");
    check("coal_rises", 40'(rises - r0), 40'd2);
    check_disp("coal_final", 5, 12);
    // random traffic, mixed increments and clears at random spacing
    for (int i = 0; i < 20; i++) begin
      pulse(1'($urandom_range(1, 0)), 1'($urandom_range(5, 0) == 0));
      repeat ($urandom_range(45, 0)) @(negedge clk);
    end
    settle("rand");
    check_disp("rand_final", m_s, m_h);
    // clear and increment together: clear wins
    pulse(1'b1, 1'b1);
    settle("clr_inc");
    check_disp("clr_inc_final", 0, m_h);
    // saturation
    for (int i = 0; i < 10005; i++) pulse(1'b1, 1'b0);
    settle("sat");
    check_disp("sat_final", 9999, 9999);
    r0 = rises;
    pulse(1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("sat_no_conv", 40'(rises - r0), 40'd0);
    check("sat_busy", 40'(busy), 40'd0);
    // reset mid-conversion
    pulse(1'b0, 1'b1);
    settle("pre_rst");
    check_disp("pre_rst_final", 0, 9999);
    pulse(1'b1, 1'b0);
    repeat (9) @(negedge clk);
    check("mid_busy_before", 40'(busy), 40'd1);
    do_reset();
    #1 check("mid_busy_after", 40'(busy), 40'd0);
    @(negedge clk);
    check_disp("mid_rst_digits", 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = rises;
    repeat (40) @(negedge clk);
    check("mid_rst_no_conv", 40'(rises - r0), 40'd0);
    read_disp(d);
    check("mid_rst_hold", d, model(0, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/score_digit_driver.md
# score_digit_driver

Upstream feeder for the 8-digit seven-segment display stage. Keeps the game's current score and high score, converts both to BCD with a sequential shift-and-add-3 (double-dabble) engine, and commits the result atomically to an 8-entry digit register file. The display stage's `refresh_rate` select picks which digit code drives `digit_holder`, which returns to the display stage.

## Interface
Parameters:
- `SCORE_W`, 14: binary width of the score and high-score counters.
- `MAX_SCORE`, 9999: saturation value. Must fit in 4 BCD digits.
- `BLANK`, 5'd31: digit code for an unlit digit. Codes 0–9 are decimal digits.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `score_inc`, in, 1: one-cycle pulse; add 1 to the score.
- `score_clr`, in, 1: one-cycle pulse; clear the score for a new game. The high score is kept.
- `refresh_rate`, in, 3: digit select from the display stage.
- `digit_holder`, out, 5: digit code for the selected position.
- `busy`, out, 1: high while a conversion is in flight.

## Operation
- **Counters** (updated on the edge that samples the pulse):
  - `score_clr` sets score to 0. It wins over a simultaneous `score_inc`.
  - `score_inc` sets score to score+1, saturating at `MAX_SCORE`. At saturation there is no change and no dirty set.
  - When the new score is greater than the high score, the high score takes the new score on the same edge.
  - Any score change sets `dirty`.
- **FSM states:** IDLE, CONV_S, CONV_H, COMMIT.
  - IDLE with `dirty`=1 → CONV_S:
    - snapshot the score into the shift register;
    - clear the BCD accumulator;
    - clear `dirty` and the bit counter.
  - A `dirty` set on that same edge by a new pulse takes priority: `dirty` stays 1.
  - CONV_S does one double-dabble step per edge:
    - each BCD nibble ≥5 gets +3;
    - then shift left 1, taking the MSB of the snapshot.
  - After `SCORE_W` steps: latch the score BCD, load the high-score snapshot, go to CONV_H.
  - CONV_H runs the same `SCORE_W` steps on the high score, then goes to COMMIT.
  - COMMIT writes all 8 digit registers in one edge, then goes to IDLE.
  - `busy` = (state ≠ IDLE).
- **Pulses during a conversion:**
  - Counters update and `dirty` sets.
  - The running conversion finishes on its old snapshots.
  - A new conversion starts from IDLE on the edge after COMMIT.
  - The display never shows a mixed old/new value.
- **Digit map:**
  - Positions 0–3: score units, tens, hundreds, thousands.
  - Positions 4–7: high-score units through thousands.
- **Leading-zero blanking (per group):**
  - Position k (k=1..3 within a group) is `BLANK` if it and every higher digit of its group are 0.
  - Units (positions 0 and 4) always show a digit.
- `digit_holder` = digit register[`refresh_rate`]. This path is combinational and has no extra latency, so the segments track the anodes.

## Timing
- **Reset values:**
  - score=0, high=0, `dirty`=0, state=IDLE, `busy`=0.
  - Digit registers 0 and 4 = 0; all other digit registers = `BLANK`.
  - `digit_holder` = 0 when `refresh_rate`∈{0,4}, otherwise 31.
- **Latency:** pulse sampled at edge E0.
  - E0: score updates.
  - E1: enter CONV_S.
  - E2–E15: score steps.
  - E16–E29: high-score steps.
  - E30: commit.
  - Total: new digits visible `2*SCORE_W+2` = 30 cycles after E0.
- **Busy window:** `busy` is high from E1 through E30 inclusive (COMMIT state). It falls after E30 unless `dirty` restarts the FSM on E31.
- **Back-to-back:** a pulse at any cycle during busy gives exactly one further conversion. Multiple pulses during busy coalesce into that one conversion.
- **Reset mid-conversion:** everything returns to its reset value immediately. There is no partial commit.
- **Arithmetic:** the BCD accumulator is 16 bits and the shift register is `SCORE_W` bits. `MAX_SCORE` keeps all nibbles ≤9.

## Test plan
- **Reset:** assert `rst_n`=0 mid-sim, sweep `refresh_rate` 0–7 → `digit_holder` = 0,31,31,31,0,31,31,31; `busy`=0.
- **Single increment:** one `score_inc` → `busy` rises at E1.
  - Positions 0 and 4 read 1 exactly 30 cycles after the pulse.
  - Other positions stay 31.
- **Multi-digit and high score:** 12 pulses spaced 40 cycles, then settle → positions 0–3 = 2,1,31,31 and positions 4–7 = 2,1,31,31.
  - Then `score_clr` + 3 pulses → positions 0–3 = 3,31,31,31 and positions 4–7 still 2,1,31,31.
- **Coalescing:** 5 `score_inc` pulses inside one busy window → exactly two conversions total (`busy` rises twice). Final score shows 5.
- **Clear priority and saturation:**
  - `score_clr` and `score_inc` in the same cycle → score 0.
  - 10005 pulses → score and high score both show 9,9,9,9. The last pulse sets no `dirty`, so no new conversion runs.
- **Reset mid-conversion:** assert `rst_n` at E10 of a conversion → digits return to reset values, `busy`=0, and no COMMIT occurs afterwards.
